// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encodings
// (common with the sequence detectors) and a counter-width helper.
package seq_pattern_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Gap counter must hold GAP_LEN-1; keep at least one bit so a zero gap still elaborates.
   function automatic int gap_cnt_w(input int gap_len);
      return (gap_len > 0) ? $clog2(gap_len + 1) : 1;
   endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: captures a pattern on start and shifts it out MSB-first,
// (repeat_n+1) times with GAP_LEN idle cycles between repetitions.
module seq_pattern_tx
   import seq_pattern_tx_pkg::*;
#(
   parameter int PAT_W   = 4,
   parameter int RPT_W   = 4,
   parameter int GAP_LEN = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [RPT_W-1:0] repeat_n,
   output logic             signal,
   output logic             sig_valid,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(PAT_W);
   localparam int GW = gap_cnt_w(GAP_LEN);

   localparam logic [BW-1:0]    BIT_LAST = BW'(PAT_W - 1);
   localparam logic [BW-1:0]    BIT_ONE  = BW'(1);
   localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
   localparam logic [GW-1:0]    GAP_ONE  = GW'(1);
   localparam logic [GW-1:0]    GAP_LOAD = (GAP_LEN > 0) ? GW'(GAP_LEN - 1) : '0;

   state_e           state_q, state_d;
   logic [PAT_W-1:0] shreg_q, shreg_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [BW-1:0]    bit_idx_q, bit_idx_d;
   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic             signal_q, signal_d;
   logic             sig_valid_q, sig_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         pat_q       <= '0;
         bit_idx_q   <= '0;
         rpt_q       <= '0;
         gap_cnt_q   <= '0;
         signal_q    <= 1'b0;
         sig_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         pat_q       <= pat_d;
         bit_idx_q   <= bit_idx_d;
         rpt_q       <= rpt_d;
         gap_cnt_q   <= gap_cnt_d;
         signal_q    <= signal_d;
         sig_valid_q <= sig_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // shreg_q[MSB] is always the bit currently on the line; signal_q mirrors it so the
   // output can be forced low in GAP/DONE/IDLE without extra gating after the flop.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      pat_d       = pat_q;
      bit_idx_d   = bit_idx_q;
      rpt_d       = rpt_q;
      gap_cnt_d   = gap_cnt_q;
      signal_d    = 1'b0;
      sig_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pat_d       = pattern;
               shreg_d     = pattern;
               rpt_d       = repeat_n;
               bit_idx_d   = BIT_LAST;
               signal_d    = pattern[PAT_W-1];
               sig_valid_d = 1'b1;
               busy_d      = 1'b1;
               state_d     = ST_SEND;
            end
         end

         ST_SEND: begin
            busy_d = 1'b1;
            if (bit_idx_q != '0) begin
               shreg_d     = shreg_q << 1;
               signal_d    = shreg_q[PAT_W-2];
               sig_valid_d = 1'b1;
               bit_idx_d   = bit_idx_q - BIT_ONE;
            end else if (rpt_q == '0) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (GAP_LEN > 0) begin
               gap_cnt_d = GAP_LOAD;
               state_d   = ST_GAP;
            end else begin
               // back-to-back repetition: first bit of the next copy follows with no bubble
               shreg_d     = pat_q;
               signal_d    = pat_q[PAT_W-1];
               sig_valid_d = 1'b1;
               bit_idx_d   = BIT_LAST;
               rpt_d       = rpt_q - RPT_ONE;
            end
         end

         ST_GAP: begin
            busy_d = 1'b1;
            if (gap_cnt_q == '0) begin
               shreg_d     = pat_q;
               signal_d    = pat_q[PAT_W-1];
               sig_valid_d = 1'b1;
               bit_idx_d   = BIT_LAST;
               rpt_d       = rpt_q - RPT_ONE;
               state_d     = ST_SEND;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_ONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign signal    = signal_q;
   assign sig_valid = sig_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
